decode_stage: RTL and testbench

- RV32I decode stage with an ID/EX pipeline register, placed between fetch and execute.
- Drives the register file read addresses from the incoming instruction and captures the returned operands.
- Bypasses a same-cycle writeback and snoops later writebacks while stalled.
- Generates the immediate and hands a decoded bundle to execute over a valid/ready handshake.

---
 rtl/pkg_config.sv | 29 ++
 rtl/imm_gen.sv | 47 ++++
 rtl/decode_stage.sv | 138 +++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_config.sv
// Shared configuration for the RV32I core: datapath sizes, base opcodes and
// immediate format classes.
package pkg_config;

   localparam int CFG_DATA_WIDTH   = 32;
   localparam int CFG_NUM_REGISTER = 32;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: classifies the opcode, builds the
// 32-bit sign-extended immediate and flags unsupported encodings.
module imm_gen
   import pkg_config::*;
(
   input  logic [31:0] i_instr,
   output imm_type_e   o_imm_type,
   output logic [31:0] o_imm,
   output logic        o_illegal
);

   imm_type_e w_type;
   logic      w_illegal;

   // Every supported opcode ends in 2'b11, so bad low bits land in default.
   always_comb begin
      w_type    = IMM_NONE;
      w_illegal = 1'b0;
      case (i_instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: w_type = IMM_I;
         OPC_STORE:                                  w_type = IMM_S;
         OPC_BRANCH:                                 w_type = IMM_B;
         OPC_LUI, OPC_AUIPC:                         w_type = IMM_U;
         OPC_JAL:                                    w_type = IMM_J;
         OPC_OP, OPC_MISC_MEM:                       w_type = IMM_NONE;
         default:                                    w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      o_imm = '0;
      case (w_type)
         IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U: o_imm = {i_instr[31:12], 12'b0};
         IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

   assign o_imm_type = w_type;
   assign o_illegal  = w_illegal;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file read, writeback bypass/snoop, immediate
// generation and the ID/EX pipeline register with a valid/ready handshake.
module decode_stage
   import pkg_config::*;
#(
   parameter int DATA_WIDTH   = CFG_DATA_WIDTH,
   parameter int NUM_REGISTER = CFG_NUM_REGISTER,
   parameter int REG_ADDR_W   = $clog2(NUM_REGISTER)
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_valid_i,
   output logic                  if_ready_o,
   input  logic [31:0]           if_instr_i,
   input  logic [DATA_WIDTH-1:0] if_pc_i,
   output logic [REG_ADDR_W-1:0] rs1_addr_o,
   output logic [REG_ADDR_W-1:0] rs2_addr_o,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic                  flush_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [DATA_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_rs1_o,
   output logic [DATA_WIDTH-1:0] ex_rs2_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
   output logic [6:0]            ex_opcode_o,
   output logic [2:0]            ex_funct3_o,
   output logic                  ex_funct7b5_o,
   output logic                  ex_illegal_o
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_pc, r_rs1, r_rs2, r_imm;
   logic [REG_ADDR_W-1:0] r_rd, r_rs1_addr, r_rs2_addr;
   logic [6:0]            r_opc;
   logic [2:0]            r_f3;
   logic                  r_f7b5, r_ill;

   imm_type_e             w_imm_type;
   logic [31:0]           w_imm32;
   logic                  w_illegal, w_accept, w_no_rd;
   logic [REG_ADDR_W-1:0] w_rs1_addr, w_rs2_addr, w_rd;
   logic [DATA_WIDTH-1:0] w_rs1, w_rs2, w_imm;

   imm_gen u_imm_gen (
      .i_instr    (if_instr_i),
      .o_imm_type (w_imm_type),
      .o_imm      (w_imm32),
      .o_illegal  (w_illegal)
   );

   // The register file writes at the same edge we capture, so a matching
   // writeback must be forwarded or the old value would be latched.
   function automatic logic [DATA_WIDTH-1:0] f_capture(
      input logic [REG_ADDR_W-1:0] addr,
      input logic [DATA_WIDTH-1:0] rf_data,
      input logic                  we,
      input logic [REG_ADDR_W-1:0] wa,
      input logic [DATA_WIDTH-1:0] wd
   );
      if (addr == '0)             return '0;
      else if (we && (wa == addr)) return wd;
      else                         return rf_data;
   endfunction

   assign w_rs1_addr = if_instr_i[19:15];
   assign w_rs2_addr = if_instr_i[24:20];
   assign rs1_addr_o = w_rs1_addr;
   assign rs2_addr_o = w_rs2_addr;

   assign if_ready_o = flush_i | ~r_valid | ex_ready_i;
   assign w_accept   = if_valid_i & if_ready_o & ~flush_i;

   assign w_no_rd = w_illegal | (w_imm_type == IMM_S) | (w_imm_type == IMM_B)
                  | (if_instr_i[6:0] == OPC_MISC_MEM);
   assign w_rd    = w_no_rd ? '0 : if_instr_i[11:7];
   assign w_imm   = DATA_WIDTH'($signed(w_imm32));
   assign w_rs1   = f_capture(w_rs1_addr, rs1_data_i, wb_we_i, wb_addr_i, wb_data_i);
   assign w_rs2   = f_capture(w_rs2_addr, rs2_data_i, wb_we_i, wb_addr_i, wb_data_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_imm      <= '0;
         r_rd       <= '0;
         r_rs1_addr <= '0;
         r_rs2_addr <= '0;
         r_opc      <= '0;
         r_f3       <= '0;
         r_f7b5     <= 1'b0;
         r_ill      <= 1'b0;
      end else begin
         if (flush_i)         r_valid <= 1'b0;
         else if (w_accept)   r_valid <= 1'b1;
         else if (ex_ready_i) r_valid <= 1'b0;

         if (w_accept) begin
            r_pc       <= if_pc_i;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rs1_addr <= w_rs1_addr;
            r_rs2_addr <= w_rs2_addr;
            r_opc      <= if_instr_i[6:0];
            r_f3       <= if_instr_i[14:12];
            r_f7b5     <= if_instr_i[30];
            r_ill      <= w_illegal;
         end else begin
            // Held operands track later writebacks, used or not.
            if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == r_rs1_addr))
               r_rs1 <= wb_data_i;
            if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == r_rs2_addr))
               r_rs2 <= wb_data_i;
         end
      end
   end

   assign ex_valid_o    = r_valid;
   assign ex_pc_o       = r_pc;
   assign ex_rs1_o      = r_rs1;
   assign ex_rs2_o      = r_rs2;
   assign ex_imm_o      = r_imm;
   assign ex_rd_addr_o  = r_rd;
   assign ex_opcode_o   = r_opc;
   assign ex_funct3_o   = r_f3;
   assign ex_funct7b5_o = r_f7b5;
   assign ex_illegal_o  = r_ill;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps followed by random
// traffic, compared against a spec-level model and a bench-owned register file.
module tb_decode_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_valid_i = 1'b0, if_ready_o;
   logic [31:0] if_instr_i = '0, if_pc_i = '0;
   logic [4:0]  rs1_addr_o, rs2_addr_o;
   logic [31:0] rs1_data_i, rs2_data_i;
   logic        wb_we_i = 1'b0;
   logic [4:0]  wb_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        flush_i = 1'b0;
   logic        ex_valid_o, ex_ready_i = 1'b1;
   logic [31:0] ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o;
   logic [4:0]  ex_rd_addr_o;
   logic [6:0]  ex_opcode_o;
   logic [2:0]  ex_funct3_o;
   logic        ex_funct7b5_o, ex_illegal_o;

   decode_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .if_instr_i(if_instr_i), .if_pc_i(if_pc_i), .rs1_addr_o(rs1_addr_o),
      .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_pc_o(ex_pc_o),
      .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_imm_o(ex_imm_o),
      .ex_rd_addr_o(ex_rd_addr_o), .ex_opcode_o(ex_opcode_o), .ex_funct3_o(ex_funct3_o),
      .ex_funct7b5_o(ex_funct7b5_o), .ex_illegal_o(ex_illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // Bench register file; x0 holds junk so the decoder's zeroing is exercised.
   logic [31:0] regs [32];
   always_comb begin
      rs1_data_i = regs[rs1_addr_o];
      rs2_data_i = regs[rs2_addr_o];
   end

   int compared = 0, mismatched = 0;

   logic        m_valid;
   logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
   logic [4:0]  m_rd, m_a1, m_a2;
   logic [6:0]  m_opc;
   logic [2:0]  m_f3;
   logic        m_f7b5, m_ill;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                      output logic [4:0] rd, output logic ill);
      int s;
      s   = ins;
      s   = s >>> 20;
      ill = 1'b0;
      imm = 32'd0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67, 7'h73: imm = s;
         7'h23: imm = (s & ~32'h1f) | 32'(ins[11:7]);
         7'h63: imm = (ins[31] ? 32'hFFFFF000 : 32'd0) + (32'(ins[7]) << 11)
                    + (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
         7'h37, 7'h17: imm = ins & 32'hFFFFF000;
         7'h6F: imm = (ins[31] ? 32'hFFF00000 : 32'd0) + (32'(ins[19:12]) << 12)
                    + (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
         7'h33, 7'h0F: imm = 32'd0;
         default: ill = 1'b1;
      endcase
      rd = (ill || ins[6:0] == 7'h23 || ins[6:0] == 7'h63 || ins[6:0] == 7'h0F)
           ? 5'd0 : ins[11:7];
   endfunction

   function automatic logic [31:0] src_val(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_we_i && wb_addr_i == a) return wb_data_i;
      return regs[a];
   endfunction

   task automatic model_reset();
      m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
      m_a1 = 0; m_a2 = 0; m_opc = 0; m_f3 = 0; m_f7b5 = 0; m_ill = 0;
   endtask

   task automatic chk_bundle(input string tag);
      chk({tag, "_valid"}, 32'(ex_valid_o), 32'(m_valid));
      if (m_valid) begin
         chk({tag, "_pc"},  ex_pc_o,  m_pc);
         chk({tag, "_rs1"}, ex_rs1_o, m_rs1);
         chk({tag, "_rs2"}, ex_rs2_o, m_rs2);
         chk({tag, "_imm"}, ex_imm_o, m_imm);
         chk({tag, "_rd"},  32'(ex_rd_addr_o), 32'(m_rd));
         chk({tag, "_dec"}, {20'd0, ex_opcode_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o},
             {20'd0, m_opc, m_f3, m_f7b5, m_ill});
      end
   endtask

   // One clock: check combinational outputs, advance the model, clock, check.
   task automatic step(input string tag);
      logic        rdy, acc, ill;
      logic [31:0] imm;
      logic [4:0]  rd;
      #1;
      rdy = flush_i | !m_valid | ex_ready_i;
      acc = if_valid_i & rdy & !flush_i;
      chk({tag, "_ifrdy"}, 32'(if_ready_o), 32'(rdy));
      chk({tag, "_raddr"}, {22'd0, rs1_addr_o, rs2_addr_o},
          {22'd0, if_instr_i[19:15], if_instr_i[24:20]});
      if (acc) begin
         ref_decode(if_instr_i, imm, rd, ill);
         m_pc = if_pc_i; m_imm = imm; m_rd = rd; m_ill = ill;
         m_a1 = if_instr_i[19:15]; m_a2 = if_instr_i[24:20];
         m_rs1 = src_val(m_a1); m_rs2 = src_val(m_a2);
         m_opc = if_instr_i[6:0]; m_f3 = if_instr_i[14:12]; m_f7b5 = if_instr_i[30];
      end else if (wb_we_i && wb_addr_i != 0) begin
         if (wb_addr_i == m_a1) m_rs1 = wb_data_i;
         if (wb_addr_i == m_a2) m_rs2 = wb_data_i;
      end
      m_valid = flush_i ? 1'b0 : acc ? 1'b1 : ex_ready_i ? 1'b0 : m_valid;
      @(posedge clk_i);
      #1;
      if (wb_we_i && wb_addr_i != 0) regs[wb_addr_i] = wb_data_i;
      chk_bundle(tag);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_v"},   32'(ex_valid_o), 32'd0);
      chk({tag, "_pc"},  ex_pc_o | ex_imm_o, 32'd0);
      chk({tag, "_ops"}, ex_rs1_o | ex_rs2_o, 32'd0);
      chk({tag, "_dec"}, {20'd0, ex_rd_addr_o, ex_opcode_o, ex_funct3_o, ex_funct7b5_o,
                          ex_illegal_o}, 32'd0);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      if_valid_i = v; if_instr_i = ins; if_pc_i = if_pc_i + 4; ex_ready_i = rdy;
      wb_we_i = we; wb_addr_i = wa; wb_data_i = wd; flush_i = 1'b0;
   endtask

   localparam logic [6:0] OPCS [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                        7'h67, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h5B};

   initial begin
      logic [31:0] ins;
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      regs[0] = 32'hDEADBEEF;
      model_reset();
      #2;
      chk_zero("reset");
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      drive(1, 32'hFFF00293, 1, 0, 0, 0);
      step("addi");
      chk("addi_imm", ex_imm_o, 32'hFFFFFFFF);
      chk("addi_rd",  32'(ex_rd_addr_o), 32'd5);
      chk("addi_rs1", ex_rs1_o, 32'd0);

      regs[3] = 32'h11;
      drive(1, 32'h003180B3, 1, 1, 5'd3, 32'h22);
      step("bypass");
      chk("bypass_rs1", ex_rs1_o, 32'h22);
      chk("bypass_rs2", ex_rs2_o, 32'h22);

      regs[7] = 32'h1234;
      drive(1, 32'h00138113, 1, 0, 0, 0);
      step("st_cap");
      drive(1, 32'h00500093, 0, 0, 0, 0);
      step("stall1");
      chk("stall1_rs1", ex_rs1_o, 32'h1234);
      drive(1, 32'h00500093, 0, 1, 5'd7, 32'hABCD);
      step("stall2");
      drive(1, 32'h00500093, 0, 0, 0, 0);
      step("stall3");
      chk("snoop_rs1", ex_rs1_o, 32'hABCD);
      chk("stall_rd",  32'(ex_rd_addr_o), 32'd2);

      drive(1, 32'h00500093, 1, 1, 5'd0, 32'h5);
      step("x0wb");
      chk("x0_rs1", ex_rs1_o, 32'd0);
      drive(0, 32'h0, 0, 1, 5'd0, 32'h5);
      step("x0snoop");
      chk("x0snoop_rs1", ex_rs1_o, 32'd0);

      drive(1, 32'hFE000EE3, 1, 0, 0, 0);
      step("beq");
      chk("beq_imm", ex_imm_o, 32'hFFFFFFFC);
      chk("beq_rd",  32'(ex_rd_addr_o), 32'd0);
      drive(1, 32'h00512423, 1, 0, 0, 0);
      step("sw");
      chk("sw_imm", ex_imm_o, 32'd8);
      chk("sw_rd",  32'(ex_rd_addr_o), 32'd0);
      drive(1, 32'h00000000, 1, 0, 0, 0);
      step("ill");
      chk("ill_flag", 32'(ex_illegal_o), 32'd1);
      chk("ill_imm",  ex_imm_o, 32'd0);

      drive(1, 32'h00138113, 0, 0, 0, 0);
      step("fl_cap");
      drive(1, 32'h12345037, 0, 0, 0, 0);
      flush_i = 1'b1;
      step("flush");
      chk("flush_v", 32'(ex_valid_o), 32'd0);
      drive(0, 32'h0, 1, 0, 0, 0);
      step("postflush");
      chk("postflush_v", 32'(ex_valid_o), 32'd0);

      for (int n = 0; n < 400; n++) begin
         ins = $urandom();
         ins[6:0] = OPCS[$urandom_range(11)];
         if ($urandom_range(15) == 0) ins[1:0] = 2'($urandom_range(2));
         drive($urandom_range(3) != 0, ins, $urandom_range(2) != 0,
               $urandom_range(1) == 1, 5'($urandom()), $urandom());
         if ($urandom_range(3) == 0) wb_addr_i = ins[19:15];
         flush_i = ($urandom_range(15) == 0);
         step("rand");
      end

      drive(1, 32'h00138113, 0, 0, 0, 0);
      step("rst_cap");
      #2;
      rst_i = 1'b1;
      #1;
      model_reset();
      chk_zero("midrst");
      @(posedge clk_i); #1;
      chk_zero("midrst_hold");
      rst_i = 1'b0;
      drive(0, 32'h0, 1, 0, 0, 0);
      step("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
